// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed seven-segment scan controller
// Double-buffered frame with per-digit blink and anti-ghosting guard before each dwell.
module seven_seg_scan #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  power,
    input  logic [5*DIGITS-1:0]   frame_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic                  load,
    output logic                  load_ack,
    output logic [4:0]            dec_data,
    output logic                  dec_power,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int DW_W  = $clog2(SCAN_DIV);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0] DIG_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(SCAN_DIV - 1);
    localparam logic [DW_W-1:0]  GUARD_V  = DW_W'(GUARD);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {S_OFF, S_GUARD, S_SHOW} state_t;

    state_t                state_q, state_d;
    logic [5*DIGITS-1:0]   stage_q, stage_d;
    logic [DIGITS-1:0]     sblink_q, sblink_d;
    logic                  pending_q, pending_d;
    logic [5*DIGITS-1:0]   disp_q, disp_d;
    logic [DIGITS-1:0]     dblink_q, dblink_d;
    logic [DW_W-1:0]       dwell_q, dwell_d;
    logic [IDX_W-1:0]      digit_q, digit_d;
    logic [FC_W-1:0]       fcnt_q, fcnt_d;
    logic                  phase_q, phase_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [4:0]            dec_data_q, dec_data_d;
    logic                  dec_power_q, dec_power_d;
    logic                  load_ack_q, load_ack_d;
    logic                  frame_tick_q, frame_tick_d;
    logic                  boundary;
    logic [4:0]            code_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_OFF;
            stage_q      <= '1;
            sblink_q     <= '0;
            pending_q    <= 1'b0;
            disp_q       <= '1;
            dblink_q     <= '0;
            dwell_q      <= '0;
            digit_q      <= '0;
            fcnt_q       <= '0;
            phase_q      <= 1'b0;
            an_q         <= '1;
            dec_data_q   <= 5'h1F;
            dec_power_q  <= 1'b0;
            load_ack_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            sblink_q     <= sblink_d;
            pending_q    <= pending_d;
            disp_q       <= disp_d;
            dblink_q     <= dblink_d;
            dwell_q      <= dwell_d;
            digit_q      <= digit_d;
            fcnt_q       <= fcnt_d;
            phase_q      <= phase_d;
            an_q         <= an_d;
            dec_data_q   <= dec_data_d;
            dec_power_q  <= dec_power_d;
            load_ack_q   <= load_ack_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        sblink_d   = sblink_q;
        pending_d  = pending_q;
        disp_d     = disp_q;
        dblink_d   = dblink_q;
        dwell_d    = dwell_q;
        digit_d    = digit_q;
        fcnt_d     = fcnt_q;
        phase_d    = phase_q;
        load_ack_d = 1'b0;
        boundary   = 1'b0;

        if (!power) begin
            state_d = S_OFF;
            dwell_d = '0;
            digit_d = '0;
            fcnt_d  = '0;
            phase_d = 1'b0;
        end else begin
            if (state_q == S_OFF) begin
                boundary = 1'b1;
            end else if (dwell_q == DW_LAST) begin
                dwell_d = '0;
                if (digit_q == DIG_LAST) begin
                    digit_d  = '0;
                    boundary = 1'b1;
                    if (fcnt_q == FC_LAST) begin
                        fcnt_d  = '0;
                        phase_d = ~phase_q;
                    end else begin
                        fcnt_d = fcnt_q + FC_W'(1);
                    end
                end else begin
                    digit_d = digit_q + IDX_W'(1);
                end
            end else begin
                dwell_d = dwell_q + DW_W'(1);
            end
            state_d = (dwell_d < GUARD_V) ? S_GUARD : S_SHOW;
        end

        // Commit reads the old staging, so a same-cycle load stays pending for the next frame.
        if (boundary && pending_q) begin
            disp_d     = stage_q;
            dblink_d   = sblink_q;
            load_ack_d = 1'b1;
            pending_d  = 1'b0;
        end
        if (load) begin
            stage_d   = frame_in;
            sblink_d  = blink_in;
            pending_d = 1'b1;
        end
        frame_tick_d = boundary;
    end

    always_comb begin
        an_d        = '1;
        dec_power_d = 1'b0;
        dec_data_d  = 5'h1F;
        code_sel    = 5'h1F;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_d == IDX_W'(i)) code_sel = disp_d[5*i +: 5];
        end
        if (state_d != S_OFF) begin
            dec_power_d = 1'b1;
            dec_data_d  = (dwell_d == '0) ? code_sel : dec_data_q;
            if (state_d == S_SHOW && !(dblink_d[digit_d] && phase_d))
                an_d[digit_d] = 1'b0;
        end
    end

    assign an         = an_q;
    assign dec_data   = dec_data_q;
    assign dec_power  = dec_power_q;
    assign load_ack   = load_ack_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - scoreboard testbench for seven_seg_scan
// Expected per-cycle outputs are derived from frame position k counted from the power-on boundary.
module tb_seven_seg_scan;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 8;
    localparam int GUARD        = 2;
    localparam int BLINK_FRAMES = 2;

    localparam logic [19:0] CODES_A = {5'd3, 5'd2, 5'd1, 5'd0};
    localparam logic [19:0] CODES_B = {5'd12, 5'd11, 5'd10, 5'd4};
    localparam logic [19:0] CODES_C = {4{5'd6}};
    localparam logic [19:0] ALL5    = {4{5'd5}};
    localparam logic [19:0] ALL9    = {4{5'd9}};
    localparam logic [19:0] BLANK   = {4{5'h1F}};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        power;
    logic        load;
    logic [19:0] frame_in;
    logic [3:0]  blink_in;
    logic        load_ack;
    logic [4:0]  dec_data;
    logic        dec_power;
    logic [3:0]  an;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [4:0] dd;
        logic       dp;
        logic       ft;
        logic       la;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    seven_seg_scan #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .power(power), .frame_in(frame_in), .blink_in(blink_in),
        .load(load), .load_ack(load_ack), .dec_data(dec_data), .dec_power(dec_power),
        .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic push_span(input int k0, input int n, input logic [19:0] codes,
                             input logic [3:0] blink, input bit ack_first);
        exp_t x;
        int dwell, dig, frame;
        for (int k = k0; k < k0 + n; k++) begin
            dwell = k % SCAN_DIV;
            dig   = (k / SCAN_DIV) % DIGITS;
            frame = k / (SCAN_DIV * DIGITS);
            x.an  = 4'hF;
            if (dwell >= GUARD && !(blink[dig] && ((frame / BLINK_FRAMES) % 2 == 1)))
                x.an[dig] = 1'b0;
            x.dd = codes[dig*5 +: 5];
            x.dp = 1'b1;
            x.ft = (k % (SCAN_DIV * DIGITS) == 0);
            x.la = ack_first && (k == k0);
            sb.push_back(x);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; power = 1'b0; load = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic power_on(input bit do_load, input logic [19:0] codes, input logic [3:0] blink);
        @(negedge clk);
        load = do_load; frame_in = codes; blink_in = blink;
        @(negedge clk);
        load = 1'b0; power = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1; power = 1'b0; load = 1'b1; frame_in = CODES_A; blink_in = 4'b0;
        @(negedge clk);
        load = 1'b0; rst_n = 1'b0; power = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({an, dec_data, dec_power, load_ack, frame_tick} !== {4'hF, 5'h1F, 3'b000}) begin
            errors++;
            $display("FAIL reset_values got an=%b dd=%h dp=%b la=%b ft=%b, expected an=1111 dd=1f dp=0 la=0 ft=0",
                     an, dec_data, dec_power, load_ack, frame_tick);
        end
        rst_n = 1'b1;
        push_span(0, 6, BLANK, 4'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({an, dec_data, dec_power, frame_tick, load_ack} !== e) begin
                errors++;
                $display("FAIL reset_release k=%0d got an=%b dd=%0d dp=%b ft=%b la=%b, expected an=%b dd=%0d dp=%b ft=%b la=%b",
                         k, an, dec_data, dec_power, frame_tick, load_ack, e.an, e.dd, e.dp, e.ft, e.la);
            end
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({an, dec_data, dec_power} !== {4'hF, 5'h1F, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got an=%b dd=%h dp=%b, expected an=1111 dd=1f dp=0", an, dec_data, dec_power);
        end
        @(negedge clk);
        rst_n = 1'b1; power = 1'b0;
    endtask

    task automatic test_power_on();
        do_reset();
        power_on(1'b1, CODES_A, 4'b0);
        push_span(0, 64, CODES_A, 4'b0, 1'b1);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({an, dec_data, dec_power, frame_tick, load_ack} !== e) begin
                errors++;
                $display("FAIL power_on k=%0d got an=%b dd=%0d dp=%b ft=%b la=%b, expected an=%b dd=%0d dp=%b ft=%b la=%b",
                         k, an, dec_data, dec_power, frame_tick, load_ack, e.an, e.dd, e.dp, e.ft, e.la);
            end
        end
    endtask

    task automatic test_load_mid_frame();
        do_reset();
        power_on(1'b1, CODES_A, 4'b0);
        push_span(0, 32, CODES_A, 4'b0, 1'b1);
        push_span(32, 32, CODES_B, 4'b0, 1'b1);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({an, dec_data, dec_power, frame_tick, load_ack} !== e) begin
                errors++;
                $display("FAIL load_mid_frame k=%0d got an=%b dd=%0d dp=%b ft=%b la=%b, expected an=%b dd=%0d dp=%b ft=%b la=%b",
                         k, an, dec_data, dec_power, frame_tick, load_ack, e.an, e.dd, e.dp, e.ft, e.la);
            end
            load = (k == 10);
            if (k == 10) frame_in = CODES_B;
        end
        load = 1'b0;
    endtask

    task automatic test_two_loads();
        do_reset();
        power_on(1'b0, BLANK, 4'b0);
        push_span(0, 32, BLANK, 4'b0, 1'b0);
        push_span(32, 32, ALL9, 4'b0, 1'b1);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({an, dec_data, dec_power, frame_tick, load_ack} !== e) begin
                errors++;
                $display("FAIL two_loads k=%0d got an=%b dd=%0d dp=%b ft=%b la=%b, expected an=%b dd=%0d dp=%b ft=%b la=%b",
                         k, an, dec_data, dec_power, frame_tick, load_ack, e.an, e.dd, e.dp, e.ft, e.la);
            end
            load = (k == 3) || (k == 7);
            if (k == 3) frame_in = ALL5;
            if (k == 7) frame_in = ALL9;
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        power_on(1'b1, CODES_A, 4'b0);
        push_span(0, 32, CODES_A, 4'b0, 1'b1);
        push_span(32, 32, CODES_B, 4'b0, 1'b1);
        push_span(64, 32, CODES_C, 4'b0, 1'b1);
        for (int k = 0; k < 96; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({an, dec_data, dec_power, frame_tick, load_ack} !== e) begin
                errors++;
                $display("FAIL back_to_back k=%0d got an=%b dd=%0d dp=%b ft=%b la=%b, expected an=%b dd=%0d dp=%b ft=%b la=%b",
                         k, an, dec_data, dec_power, frame_tick, load_ack, e.an, e.dd, e.dp, e.ft, e.la);
            end
            load = (k == 20) || (k == 31);
            if (k == 20) frame_in = CODES_B;
            if (k == 31) frame_in = CODES_C;
        end
        load = 1'b0;
    endtask

    task automatic test_blink();
        do_reset();
        power_on(1'b1, CODES_A, 4'b0001);
        push_span(0, 256, CODES_A, 4'b0001, 1'b1);
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({an, dec_data, dec_power, frame_tick, load_ack} !== e) begin
                errors++;
                $display("FAIL blink k=%0d got an=%b dd=%0d dp=%b ft=%b la=%b, expected an=%b dd=%0d dp=%b ft=%b la=%b",
                         k, an, dec_data, dec_power, frame_tick, load_ack, e.an, e.dd, e.dp, e.ft, e.la);
            end
        end
        blink_in = 4'b0;
    endtask

    task automatic test_power_drop();
        do_reset();
        power_on(1'b1, CODES_A, 4'b0);
        push_span(0, 23, CODES_A, 4'b0, 1'b1);
        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({an, dec_data, dec_power, frame_tick, load_ack} !== e) begin
                errors++;
                $display("FAIL pre_drop k=%0d got an=%b dd=%0d dp=%b ft=%b la=%b, expected an=%b dd=%0d dp=%b ft=%b la=%b",
                         k, an, dec_data, dec_power, frame_tick, load_ack, e.an, e.dd, e.dp, e.ft, e.la);
            end
        end
        power = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({an, dec_data, dec_power, frame_tick, load_ack} !== {4'hF, 5'h1F, 3'b000}) begin
                errors++;
                $display("FAIL power_off k=%0d got an=%b dd=%h dp=%b ft=%b la=%b, expected an=1111 dd=1f dp=0 ft=0 la=0",
                         k, an, dec_data, dec_power, frame_tick, load_ack);
            end
        end
        power = 1'b1;
        push_span(0, 16, CODES_A, 4'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({an, dec_data, dec_power, frame_tick, load_ack} !== e) begin
                errors++;
                $display("FAIL repower k=%0d got an=%b dd=%0d dp=%b ft=%b la=%b, expected an=%b dd=%0d dp=%b ft=%b la=%b",
                         k, an, dec_data, dec_power, frame_tick, load_ack, e.an, e.dd, e.dp, e.ft, e.la);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; power = 1'b0; load = 1'b0; frame_in = '0; blink_in = '0;
        test_reset();
        test_power_on();
        test_load_mid_frame();
        test_two_loads();
        test_back_to_back();
        test_blink();
        test_power_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed scan controller for the multi-digit seven-segment display. It holds a full display frame of 5-bit digit codes and steps through the digits one at a time. For each digit it drives the shared `seven_seg_dec` input (`dec_data`, `dec_power`) and the active-low digit anodes. Frame updates from the shop control logic go through a staging/display double buffer and are committed only at frame boundaries, so a frame never tears; per-digit blink and anti-ghosting guard intervals are also handled here.

## Interface
- `DIGITS`, 8, number of multiplexed digits (≥2)
- `SCAN_DIV`, 50000, clock cycles each digit is dwelt on (≥2)
- `GUARD`, 500, leading cycles of each dwell with all anodes off (1 ≤ GUARD < SCAN_DIV)
- `BLINK_FRAMES`, 64, frames per blink half-period (≥1)

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `power`  in  1  display enable; 0 = display off
- `frame_in`  in  5*DIGITS  digit codes; digit i at [5i+4:5i], seven_seg_dec encoding
- `blink_in`  in  DIGITS  per-digit blink enable, captured with `frame_in`
- `load`  in  1  request to capture `frame_in`/`blink_in`
- `load_ack`  out  1  one-cycle pulse when the staged frame becomes the displayed frame
- `dec_data`  out  5  code to decoder
- `dec_power`  out  1  decoder power
- `an`  out  DIGITS  anode enables, active-low, at most one bit low
- `frame_tick`  out  1  one-cycle pulse at each frame boundary

## Operation
- Registers: staging buffer and blink mask, `pending` flag, display buffer and blink mask, `dwell_cnt` (0..SCAN_DIV-1), `digit_idx` (0..DIGITS-1), `frame_cnt` (0..BLINK_FRAMES-1), `blink_phase`, and the state.
- States:
  - OFF: `power`=0.
  - GUARD: `dwell_cnt` < GUARD.
  - SHOW: `dwell_cnt` ≥ GUARD.
- OFF → GUARD when `power` is 1. This transition counts as a frame boundary. `digit_idx`, `dwell_cnt`, `frame_cnt` and `blink_phase` start at 0.
- Any state → OFF on the cycle after `power` is sampled 0. In OFF: `an` all 1, `dec_power`=0, `dec_data`=5'b11111, and all counters are held at 0.
- `dwell_cnt` increments every cycle outside OFF.
  - At SCAN_DIV-1 it wraps to 0 and `digit_idx` advances.
  - When `digit_idx` wraps from DIGITS-1 to 0, that is a frame boundary: `frame_tick` pulses and `frame_cnt` advances.
  - When `frame_cnt` wraps, `blink_phase` toggles.
- `dec_data` = display code of `digit_idx`, loaded at the start of each dwell (GUARD); `dec_power`=1 outside OFF.
- In SHOW, `an[digit_idx]`=0 unless the display blink bit is set and `blink_phase`=1. All other bits are 1.
- Load handshake:
  - A cycle with `load`=1 copies `frame_in`/`blink_in` into staging and sets `pending`. This happens in any state, including OFF.
  - If `pending` is already set, staging is overwritten; the latest load wins and no extra ack is generated.
- Commit: at a frame boundary with `pending`=1, display ← staging, `load_ack` pulses, and `pending` clears.
- Load and commit in the same cycle: the old staging is committed; the new data is captured into staging and `pending` stays 1.

## Timing
- All outputs are registered.
- Reset values: `an` all 1, `dec_data`=5'b11111, `dec_power`=0, `load_ack`=0, `frame_tick`=0, state OFF, all counters 0, `pending`=0, display and staging codes all 5'b11111, blink masks 0.
- `rst_n` low mid-frame returns everything to reset values immediately, without waiting for a clock edge. Any pending load is discarded.
- The first SHOW cycle for digit 0 comes GUARD+1 cycles after `power` is sampled 1.
- A digit's anode is low for exactly SCAN_DIV-GUARD consecutive cycles. A frame lasts DIGITS*SCAN_DIV cycles.
- Commit latency: new data appears in the first dwell after the next boundary. Worst case from `load` to display is one full frame.
- `frame_tick` and `load_ack` assert in the same cycle when a commit occurs.
- `dec_data` never changes while any `an` bit is low.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2.
- Reset with `power`=1: hold `rst_n`=0 → `an`=4'b1111, `dec_data`=5'b11111, `dec_power`=0. Release → digit 0 is shown starting 3 cycles later.
- Power-on with `load` pulsed in OFF, codes {3,2,1,0}:
  - `load_ack` pulses on the power-on boundary.
  - `an` cycles through 1110, 1101, 1011, 0111, each low for 6 cycles and preceded by 2 cycles of 1111.
  - `dec_data` reads 0,1,2,3.
  - `frame_tick` fires every 32 cycles.
- Load mid-frame (cycle 10): the old frame completes unchanged. `load_ack` and `frame_tick` coincide at cycle 32, and the new codes are shown from digit 0.
- Two loads before a boundary, codes 5 then 9 in all digits → exactly one `load_ack`, and 9 is displayed.
- Blink: `blink_in`=4'b0001 → `an[0]` stays 1 during frames 2-3 and 6-7, and goes low normally in frames 0-1 and 4-5. The other digits are unaffected.
- Drop `power` at SHOW cycle 5 of digit 2 → next cycle `an`=1111, `dec_power`=0. Re-raise `power` → scanning restarts at digit 0 with GUARD first.
